floor_scheduler: RTL and testbench

FLOOR_SCHEDULER -- requirements
Module: floor_scheduler

---
 rtl/floor_scheduler.sv | 115 +++++++++++
 tb/tb_floor_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/floor_scheduler.sv
// floor_scheduler: SCAN elevator controller with a pending-call mask mirrored to a request memory
module floor_scheduler #(
    parameter int FLOORS      = 8,
    parameter int MOVE_CYCLES = 8,
    parameter int DOOR_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  call_req,
    output logic [2:0]  cur_floor,
    output logic        dir_up,
    output logic        moving,
    output logic        door_open,
    output logic        idle,
    output logic        mem_wr_en,
    output logic [7:0]  mem_data
);
    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

    state_t            r_state;
    logic [7:0]        r_timer;
    logic [FLOORS-1:0] r_pending;
    logic [2:0]        r_floor;
    logic              r_dir;
    logic              r_moving;
    logic              r_door;
    logic              r_idle;
    logic              r_wr;

    logic [FLOORS-1:0] w_merged;
    logic [FLOORS-1:0] w_cur_hot;
    logic [FLOORS-1:0] w_eval_mask;
    logic [FLOORS-1:0] w_eval_hot;
    logic [FLOORS-1:0] w_lt;
    logic [FLOORS-1:0] w_le;
    logic [FLOORS-1:0] w_next_pending;
    logic [2:0]        w_next_floor;
    logic [2:0]        w_eval_floor;
    logic              w_here;
    logic              w_up_any;
    logic              w_dn_any;
    logic              w_ahead;
    logic              w_behind;
    logic              w_decide;

    // The decision is taken against the floor the car will occupy after this edge;
    // in DOOR the current floor is masked so same-floor calls are absorbed.
    assign w_merged       = r_pending | call_req;
    assign w_cur_hot      = FLOORS'(1) << r_floor;
    assign w_next_floor   = r_dir ? r_floor + 3'd1 : r_floor - 3'd1;
    assign w_eval_floor   = (r_state == S_MOVE) ? w_next_floor : r_floor;
    assign w_eval_mask    = (r_state == S_DOOR) ? (w_merged & ~w_cur_hot) : w_merged;
    assign w_eval_hot     = FLOORS'(1) << w_eval_floor;
    assign w_lt           = w_eval_hot - FLOORS'(1);
    assign w_le           = w_lt | w_eval_hot;
    assign w_here         = |(w_eval_mask & w_eval_hot);
    assign w_up_any       = |(w_eval_mask & ~w_le);
    assign w_dn_any       = |(w_eval_mask & w_lt);
    assign w_ahead        = r_dir ? w_up_any : w_dn_any;
    assign w_behind       = r_dir ? w_dn_any : w_up_any;
    assign w_decide       = (r_state == S_IDLE) || (r_timer == 8'd0);
    assign w_next_pending = (w_decide && w_here) ? (w_eval_mask & ~w_eval_hot) : w_eval_mask;

    // FSM, timers, pending mask and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_timer   <= 8'd0;
            r_pending <= '0;
            r_floor   <= 3'd0;
            r_dir     <= 1'b1;
            r_moving  <= 1'b0;
            r_door    <= 1'b0;
            r_idle    <= 1'b1;
            r_wr      <= 1'b0;
        end else begin
            r_wr      <= 1'b1;
            r_pending <= w_next_pending;
            if (!w_decide) begin
                r_timer <= r_timer - 8'd1;
            end else begin
                if (r_state == S_MOVE)
                    r_floor <= w_next_floor;
                if (w_here) begin
                    r_state  <= S_DOOR;
                    r_timer  <= 8'(DOOR_CYCLES - 1);
                    r_moving <= 1'b0;
                    r_door   <= 1'b1;
                    r_idle   <= 1'b0;
                end else if (w_ahead || w_behind) begin
                    r_state  <= S_MOVE;
                    r_timer  <= 8'(MOVE_CYCLES - 1);
                    r_dir    <= r_dir ^ !w_ahead;
                    r_moving <= 1'b1;
                    r_door   <= 1'b0;
                    r_idle   <= 1'b0;
                end else begin
                    r_state  <= S_IDLE;
                    r_timer  <= 8'd0;
                    r_moving <= 1'b0;
                    r_door   <= 1'b0;
                    r_idle   <= 1'b1;
                end
            end
        end
    end

    assign cur_floor = r_floor;
    assign dir_up    = r_dir;
    assign moving    = r_moving;
    assign door_open = r_door;
    assign idle      = r_idle;
    assign mem_wr_en = r_wr;
    assign mem_data  = r_pending;
endmodule

// File: tb/tb_floor_scheduler.sv
// tb_floor_scheduler: directed scenarios plus random calls checked against a floor-level reference model
module tb_floor_scheduler;
    localparam int MOVE_CYCLES = 8;
    localparam int DOOR_CYCLES = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] call_req = 8'h00;
    logic [2:0] cur_floor;
    logic       dir_up, moving, door_open, idle, mem_wr_en;
    logic [7:0] mem_data;

    always #5 clk = ~clk;

    floor_scheduler #(.FLOORS(8), .MOVE_CYCLES(MOVE_CYCLES), .DOOR_CYCLES(DOOR_CYCLES)) dut (
        .clk(clk), .reset(reset), .call_req(call_req), .cur_floor(cur_floor), .dir_up(dir_up),
        .moving(moving), .door_open(door_open), .idle(idle), .mem_wr_en(mem_wr_en), .mem_data(mem_data)
    );

    wire [15:0] dut_vec = {cur_floor, dir_up, moving, door_open, idle, mem_wr_en, mem_data};

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: 0 idle, 1 travelling, 2 door open; m_cnt counts cycles left in the activity.
    int m_state = 0;
    int m_floor = 0;
    int m_cnt = 0;
    bit m_up = 1'b1;
    bit m_wr = 1'b0;
    bit m_pend[8];
    int doors[$];
    logic [7:0] door_data[$];

    function automatic logic [15:0] exp_vec();
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = m_pend[i];
        return {3'(m_floor), m_up, m_state == 1, m_state == 2, m_state == 0, m_wr, p};
    endfunction

    // 1 = serve here, 2 = continue in current direction, 3 = reverse, 0 = nothing to do
    function automatic int decide(int f, bit up, bit mm[8]);
        bit a = 1'b0, b = 1'b0, h = 1'b0;
        for (int i = 0; i < 8; i++)
            if (mm[i]) begin
                if (i == f) h = 1'b1;
                else if ((i > f) == up) a = 1'b1;
                else b = 1'b1;
            end
        return h ? 1 : a ? 2 : b ? 3 : 0;
    endfunction

    task automatic model_step(input logic [7:0] c, input logic r);
        bit mm[8];
        int act;
        if (r) begin
            m_state = 0; m_floor = 0; m_up = 1'b1; m_cnt = 0; m_wr = 1'b0;
            for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
            return;
        end
        m_wr = 1'b1;
        for (int i = 0; i < 8; i++) mm[i] = m_pend[i] | c[i];
        act = -1;
        if (m_state == 0) act = decide(m_floor, m_up, mm);
        else begin
            if (m_state == 2) mm[m_floor] = 1'b0;
            m_cnt--;
            if (m_cnt == 0) begin
                if (m_state == 1) m_floor += m_up ? 1 : -1;
                act = decide(m_floor, m_up, mm);
            end
        end
        if (act == 1) begin
            mm[m_floor] = 1'b0; m_state = 2; m_cnt = DOOR_CYCLES;
        end else if (act == 2 || act == 3) begin
            if (act == 3) m_up = !m_up;
            m_state = 1; m_cnt = MOVE_CYCLES;
        end else if (act == 0) begin
            m_state = 0; m_cnt = 0;
        end
        m_pend = mm;
    endtask

    task automatic tick(input logic [7:0] c, input logic r);
        call_req = c;
        reset = r;
        model_step(c, r);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        logic prev;
        prev = door_open;
        for (int k = 0; k < n; k++) begin
            tick(8'h00, 1'b0);
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL run_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec());
            end
            if (door_open && !prev) begin
                doors.push_back(int'(cur_floor));
                door_data.push_back(mem_data);
            end
            prev = door_open;
        end
    endtask

    task automatic test_reset();
        tick(8'hFF, 1'b1);
        tick(8'h00, 1'b1);
        n_chk++;
        if (dut_vec !== 16'h1200) begin
            n_fail++; $display("FAIL reset_state got=%h exp=%h", dut_vec, 16'h1200);
        end
        tick(8'h00, 1'b0);
        n_chk++;
        if (dut_vec !== 16'h1300 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL reset_release got=%h exp=%h", dut_vec, 16'h1300);
        end
    endtask

    task automatic test_door_here();
        int open_cnt;
        tick(8'h01, 1'b0);
        n_chk++;
        if (door_open !== 1'b1 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL door_here_open got=%h exp=%h", dut_vec, exp_vec());
        end
        open_cnt = 1;
        for (int k = 0; k < 6; k++) begin
            tick(8'h00, 1'b0);
            open_cnt += int'(door_open);
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL door_here_model got=%h exp=%h", dut_vec, exp_vec());
            end
        end
        n_chk++;
        if (open_cnt != DOOR_CYCLES || idle !== 1'b1 || mem_data !== 8'h00) begin
            n_fail++; $display("FAIL door_here_len got=%0d/%b/%h exp=%0d/1/00", open_cnt, idle, mem_data, DOOR_CYCLES);
        end
    endtask

    task automatic test_travel_up();
        tick(8'h08, 1'b0);
        n_chk++;
        if (moving !== 1'b1 || dir_up !== 1'b1 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL travel_start got=%h exp=%h", dut_vec, exp_vec());
        end
        for (int k = 1; k <= 24; k++) begin
            tick(8'h00, 1'b0);
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL travel_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
            end
            if (k % 8 == 0) begin
                n_chk++;
                if (int'(cur_floor) != k / 8) begin
                    n_fail++; $display("FAIL travel_floor k=%0d got=%0d exp=%0d", k, cur_floor, k / 8);
                end
            end
        end
        n_chk++;
        if (door_open !== 1'b1 || mem_data !== 8'h00) begin
            n_fail++; $display("FAIL travel_arrive got=%b/%h exp=1/00", door_open, mem_data);
        end
        run(6);
    endtask

    task automatic test_scan();
        tick(8'h00, 1'b1);
        tick(8'h00, 1'b0);
        tick(8'h04, 1'b0);
        run(30);
        tick(8'h40, 1'b0);
        run(8);
        n_chk++;
        if (cur_floor !== 3'd3 || moving !== 1'b1) begin
            n_fail++; $display("FAIL scan_at3 got=%0d/%b exp=3/1", cur_floor, moving);
        end
        tick(8'h02, 1'b0);
        doors.delete();
        run(100);
        n_chk++;
        if (doors.size() != 2 || doors[0] != 6 || doors[1] != 1) begin
            n_fail++; $display("FAIL scan_order got=%p exp='{6,1}", doors);
        end
        n_chk++;
        if (cur_floor !== 3'd1 || dir_up !== 1'b0 || idle !== 1'b1) begin
            n_fail++; $display("FAIL scan_end got=%0d/%b/%b exp=1/0/1", cur_floor, dir_up, idle);
        end
    endtask

    task automatic test_two_stops();
        tick(8'h00, 1'b1);
        tick(8'h00, 1'b0);
        tick(8'h24, 1'b0);
        n_chk++;
        if (mem_data !== 8'h24) begin
            n_fail++; $display("FAIL two_stops_mask got=%h exp=24", mem_data);
        end
        doors.delete();
        door_data.delete();
        run(70);
        n_chk++;
        if (doors.size() != 2 || doors[0] != 2 || doors[1] != 5 ||
            door_data[0] !== 8'h20 || door_data[1] !== 8'h00) begin
            n_fail++; $display("FAIL two_stops_seq got=%p/%p exp='{2,5}/'{20,00}", doors, door_data);
        end
    endtask

    task automatic test_door_recall();
        int open_cnt;
        open_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick(8'h20, 1'b0);
            open_cnt += int'(door_open);
            n_chk++;
            if (dut_vec !== exp_vec() || mem_data[5] !== 1'b0) begin
                n_fail++; $display("FAIL recall_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
            end
        end
        n_chk++;
        if (open_cnt != DOOR_CYCLES || idle !== 1'b1 || cur_floor !== 3'd5) begin
            n_fail++; $display("FAIL recall_len got=%0d/%b exp=%0d/1", open_cnt, idle, DOOR_CYCLES);
        end
    endtask

    task automatic test_reset_mid_move();
        bit found;
        tick(8'h00, 1'b1);
        tick(8'h00, 1'b0);
        tick(8'h80, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            tick(8'h00, 1'b0);
            found = (cur_floor == 3'd4);
        end
        n_chk++;
        if (!found || moving !== 1'b1) begin
            n_fail++; $display("FAIL mid_move_reach got=%0d/%b exp=4/1", cur_floor, moving);
        end
        tick(8'hFF, 1'b1);
        n_chk++;
        if (cur_floor !== 3'd0 || mem_wr_en !== 1'b0 || idle !== 1'b1 || mem_data !== 8'h00) begin
            n_fail++; $display("FAIL mid_move_reset got=%h exp=1200", dut_vec);
        end
        tick(8'h00, 1'b0);
        n_chk++;
        if (dut_vec !== 16'h1300 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL mid_move_release got=%h exp=1300", dut_vec);
        end
    endtask

    task automatic test_random();
        logic [7:0] c;
        logic r;
        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(0, 299) == 0);
            c = ($urandom_range(0, 11) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
            tick(c, r);
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL random k=%0d call=%h rst=%b got=%h exp=%h", k, c, r, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_door_here();
        test_travel_up();
        test_scan();
        test_two_stops();
        test_door_recall();
        test_reset_mid_move();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
